// File: rtl/vending_input_conditioner.sv
// Input front end for the vending FSM: synchronizes and debounces the coin and
// button sensors, serializes coins into single-cycle pulses and latches the drink selection.

module vic_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_event
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_s;
    logic             w_accept;

    assign w_s      = r_sync[1];
    assign w_accept = (w_s != r_stable) && (r_cnt == LAST);
    // Only the 0->1 accept is an event; release is silent.
    assign o_event  = w_accept & w_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync   <= '0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (w_s == r_stable) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= w_s;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

module vending_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic coin_n_raw,
    input  logic coin_d_raw,
    input  logic coin_q_raw,
    input  logic btn_diet_raw,
    input  logic btn_soda_raw,
    input  logic GiveDiet,
    input  logic GiveSoda,
    output logic N_in,
    output logic D_in,
    output logic Q_in,
    output logic diet_in,
    output logic soda_in,
    output logic coin_dropped
);
    localparam int NUM_CH  = 5;
    localparam int CH_DIET = 3;
    localparam int CH_SODA = 4;

    logic [NUM_CH-1:0] w_raw;
    logic [NUM_CH-1:0] w_ev;
    logic [2:0]        w_coin_ev;
    logic [2:0]        w_issue;
    logic [2:0]        w_pend_nxt;
    logic              w_drop;

    logic [2:0]        r_pend;
    logic [2:0]        r_issue;
    logic              r_drop;
    logic              r_diet;
    logic              r_soda;

    // Channel order {soda, diet, q, d, n}; coin bits line up with r_pend.
    assign w_raw = {btn_soda_raw, btn_diet_raw, coin_q_raw, coin_d_raw, coin_n_raw};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        vic_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .i_raw   (w_raw[g]),
            .o_event (w_ev[g])
        );
    end

    assign w_coin_ev = w_ev[2:0];

    always_comb begin
        w_issue = 3'b000;
        if (r_pend[2])      w_issue = 3'b100;
        else if (r_pend[1]) w_issue = 3'b010;
        else if (r_pend[0]) w_issue = 3'b001;
    end

    // A fresh event on the flag being issued re-arms it; one on a waiting flag is lost.
    assign w_pend_nxt = (r_pend & ~w_issue) | w_coin_ev;
    assign w_drop     = |(w_coin_ev & r_pend & ~w_issue);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend  <= '0;
            r_issue <= '0;
            r_drop  <= 1'b0;
            r_diet  <= 1'b0;
            r_soda  <= 1'b0;
        end else begin
            r_pend  <= w_pend_nxt;
            r_issue <= w_issue;
            r_drop  <= w_drop;
            if (GiveDiet | GiveSoda) begin
                r_diet <= 1'b0;
                r_soda <= 1'b0;
            end else if (w_ev[CH_DIET] & w_ev[CH_SODA]) begin
                r_diet <= r_diet;
                r_soda <= r_soda;
            end else if (w_ev[CH_DIET]) begin
                r_diet <= 1'b1;
                r_soda <= 1'b0;
            end else if (w_ev[CH_SODA]) begin
                r_diet <= 1'b0;
                r_soda <= 1'b1;
            end
        end
    end

    assign N_in         = r_issue[0];
    assign D_in         = r_issue[1];
    assign Q_in         = r_issue[2];
    assign coin_dropped = r_drop;
    assign diet_in      = r_diet;
    assign soda_in      = r_soda;
endmodule
